tt_um_lexander_edge_meter: RTL and testbench

//  Measures an external pulse train: counts rising edges of ui_in[0] over a programmable

---
 rtl/tt_um_lexander_edge_meter_pkg.sv | 25 ++
 rtl/tt_um_lexander_edge_meter_if.sv | 22 ++
 rtl/tt_edge_sync_detect.sv | 27 ++
 rtl/tt_um_lexander_edge_meter.sv | 119 +++++++++++
 tb/tb_tt_um_lexander_edge_meter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_um_lexander_edge_meter_pkg.sv
// Shared definitions for the edge meter: FSM encoding, pin bit positions and
// fixed output constants.
package tt_um_lexander_edge_meter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    localparam int unsigned UI_SIG_IN       = 0;
    localparam int unsigned UI_START        = 1;
    localparam int unsigned UI_CONT_MODE    = 2;
    localparam int unsigned UI_BYTE_SEL     = 3;
    localparam int unsigned UI_GATE_EXP_LSB = 4;
    localparam int unsigned UI_GATE_EXP_MSB = 7;

    localparam int unsigned UIO_VALID = 0;
    localparam int unsigned UIO_BUSY  = 1;
    localparam int unsigned UIO_OVF   = 2;

    // Gate length is 2^(gate_exp + GATE_EXP_OFFSET) cycles.
    localparam int unsigned GATE_EXP_OFFSET = 4;
    localparam logic [7:0]  UIO_OE_MASK     = 8'h07;

endpackage

// File: rtl/tt_um_lexander_edge_meter_if.sv
// Tiny Tapeout pin bundle for the edge meter; master drives the inputs,
// slave is the tile side.
interface tt_um_lexander_edge_meter_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/tt_edge_sync_detect.sv
// Synchroniser chain followed by a registered rising-edge pulse; pulse appears
// SYNC_STAGES+1 clocks after the pin changes.
module tt_edge_sync_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            s_d   <= 1'b0;
            rise  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            s_d   <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~s_d;
        end
    end

endmodule

// File: rtl/tt_um_lexander_edge_meter.sv
// Edge meter tile: counts rising edges of ui_in[0] over a 2^(gate_exp+4) cycle
// gate window and publishes a saturating count on uo_out.
module tt_um_lexander_edge_meter
    import tt_um_lexander_edge_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GATE_W      = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t              state;
    logic [GATE_W-1:0]   timer;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    result;
    logic                valid;
    logic                ovf;

    logic                sig_rise;
    logic                start_rise;
    logic                cont_mode;
    logic [3:0]          gate_exp;
    logic [GATE_W-1:0]   gate_reload;
    logic                at_max;
    logic                sat_hit;
    logic [CNT_W-1:0]    count_next;
    logic [15:0]         result_w;
    logic                unused;

    assign unused = ^{ena, uio_in};

    tt_edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[UI_SIG_IN]),
        .rise  (sig_rise)
    );

    tt_edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[UI_START]),
        .rise  (start_rise)
    );

    assign cont_mode   = ui_in[UI_CONT_MODE];
    assign gate_exp    = ui_in[UI_GATE_EXP_MSB:UI_GATE_EXP_LSB];
    assign gate_reload = (GATE_W'(1) << (GATE_EXP_OFFSET + 32'(gate_exp))) - GATE_W'(1);

    // Count + current edge, held at all-ones; sat_hit flags a lost edge.
    assign at_max     = (count == '1);
    assign sat_hit    = sig_rise & at_max;
    assign count_next = (sig_rise && !at_max) ? count + CNT_W'(1) : count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            timer  <= '0;
            count  <= '0;
            result <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state <= ST_GATE;
                        timer <= gate_reload;
                        count <= '0;
                        valid <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                ST_GATE: begin
                    ovf <= ovf | sat_hit;
                    if (timer == '0) begin
                        // Terminal cycle: its edge still belongs to this window.
                        result <= count_next;
                        valid  <= 1'b1;
                        count  <= '0;
                        if (cont_mode) begin
                            timer <= gate_reload;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        count <= count_next;
                        timer <= timer - GATE_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign result_w = 16'(result);

    always_comb begin
        uo_out = ui_in[UI_BYTE_SEL] ? result_w[15:8] : result_w[7:0];
    end

    always_comb begin
        uio_out            = '0;
        uio_out[UIO_VALID] = valid;
        uio_out[UIO_BUSY]  = (state == ST_GATE);
        uio_out[UIO_OVF]   = ovf;
    end

    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_lexander_edge_meter.sv
// Directed bench for the edge meter; a second instance with an 8-bit counter
// exercises saturation within a short gate window.
module tb_tt_um_lexander_edge_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_gen = 1'b0;
    logic        sig_man = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        byte_sel = 1'b0;
    logic [3:0]  gexp = 4'd0;
    int unsigned sig_half = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n;
    int          total;
    logic        busy;
    logic        valid;
    logic        ovf;

    always #5 clk = ~clk;

    tt_um_lexander_edge_meter_if pins ();
    tt_um_lexander_edge_meter_if pins_s ();

    assign pins.ena     = 1'b1;
    assign pins.uio_in  = 8'h00;
    assign pins.ui_in   = {gexp, byte_sel, cont, start, sig_gen | sig_man};
    assign pins_s.ena    = 1'b1;
    assign pins_s.uio_in = 8'h00;
    assign pins_s.ui_in  = {gexp, byte_sel, cont, start, sig_gen | sig_man};

    assign valid = pins.uio_out[0];
    assign busy  = pins.uio_out[1];
    assign ovf   = pins.uio_out[2];

    tt_um_lexander_edge_meter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (pins.ena),
        .ui_in   (pins.ui_in),
        .uo_out  (pins.uo_out),
        .uio_in  (pins.uio_in),
        .uio_out (pins.uio_out),
        .uio_oe  (pins.uio_oe)
    );

    tt_um_lexander_edge_meter #(.CNT_W(8)) dut_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (pins_s.ena),
        .ui_in   (pins_s.ui_in),
        .uo_out  (pins_s.uo_out),
        .uio_in  (pins_s.uio_in),
        .uio_out (pins_s.uio_out),
        .uio_oe  (pins_s.uio_oe)
    );

    // Square wave on sig_in: toggles every sig_half clocks, held low when 0.
    initial begin
        int unsigned ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (sig_half != 0) begin
                ph++;
                if (ph >= sig_half) begin
                    ph = 0;
                    sig_gen = ~sig_gen;
                end
            end else begin
                ph = 0;
                sig_gen = 1'b0;
            end
        end
    end

    task automatic tick(input int cycles = 1);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input logic val, input int budget, input string tag);
        int k;
        k = 0;
        while (busy !== val && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(busy), 32'(val));
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_uo_out", 32'(pins.uo_out), 32'h00);
        check("rst_uio_out", 32'(pins.uio_out), 32'h00);
        check("rst_uio_oe", 32'(pins.uio_oe), 32'h07);
        rst_n = 1'b1;
        tick(2);

        // L=16, sig period 2: 8 edges, window is exactly 16 cycles
        gexp = 4'd0;
        sig_half = 1;
        tick(4);
        start = 1'b1;
        wait_busy(1'b1, 10, "t2_enter");
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        start = 1'b0;
        check("t2_busy_len", 32'(n), 32'd16);
        check("t2_uo_out", 32'(pins.uo_out), 32'h08);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_ovf", 32'(ovf), 32'd0);

        // L=64, sig period 8: 8 edges; upper byte is zero
        gexp = 4'd2;
        sig_half = 4;
        tick(4);
        start = 1'b1;
        wait_busy(1'b1, 10, "t3_enter");
        start = 1'b0;
        wait_busy(1'b0, 100, "t3_done");
        check("t3_lo", 32'(pins.uo_out), 32'h08);
        byte_sel = 1'b1;
        #1;
        check("t3_hi", 32'(pins.uo_out), 32'h00);
        byte_sel = 1'b0;
        #1;
        check("t3_valid", 32'(valid), 32'd1);

        // Asynchronous reset in the middle of an active window
        gexp = 4'd0;
        sig_half = 1;
        tick(4);
        start = 1'b1;
        wait_busy(1'b1, 10, "t1_enter");
        tick(5);
        check("t1_busy_mid", 32'(busy), 32'd1);
        check("t1_valid_mid", 32'(valid), 32'd0);
        check("t1_uo_pre", 32'(pins.uo_out), 32'h08);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_uo_async", 32'(pins.uo_out), 32'h00);
        check("t1_uio_async", 32'(pins.uio_out), 32'h00);
        check("t1_oe_async", 32'(pins.uio_oe), 32'h07);
        start = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_valid_after", 32'(valid), 32'd0);
        check("t1_uo_after", 32'(pins.uo_out), 32'h00);

        // Continuous mode: 4 edges per 16-cycle window, no gap between windows
        gexp = 4'd0;
        sig_half = 2;
        cont = 1'b1;
        tick(4);
        start = 1'b1;
        wait_busy(1'b1, 10, "t5_enter");
        start = 1'b0;
        total = 0;
        for (int w = 0; w < 4; w++) begin
            tick(16);
            check("t5_result", 32'(pins.uo_out), 32'h04);
            check("t5_busy", 32'(busy), 32'd1);
            check("t5_valid", 32'(valid), 32'd1);
            total += int'(pins.uo_out);
        end
        check("t5_total", 32'(total), 32'd16);
        tick(5);
        cont = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("t5_stop_len", 32'(n), 32'd11);
        check("t5_last", 32'(pins.uo_out), 32'h04);

        // Single edge landing in the terminal cycle, plus a start during GATE
        sig_half = 0;
        gexp = 4'd0;
        tick(6);
        start = 1'b1;
        tick(6);
        start = 1'b0;
        tick(4);
        start = 1'b1;
        tick(6);
        sig_man = 1'b1;
        tick(3);
        check("t6_last_gate", 32'(busy), 32'd1);
        tick();
        check("t6_done", 32'(busy), 32'd0);
        check("t6_edge_in", 32'(pins.uo_out), 32'h01);
        check("t6_valid", 32'(valid), 32'd1);
        start = 1'b0;
        sig_man = 1'b0;
        tick(10);
        check("t6_no_restart", 32'(busy), 32'd0);

        // Same edge one cycle later falls outside the window
        start = 1'b1;
        tick(6);
        start = 1'b0;
        tick(11);
        sig_man = 1'b1;
        tick(3);
        check("t6b_done", 32'(busy), 32'd0);
        check("t6b_edge_out", 32'(pins.uo_out), 32'h00);
        sig_man = 1'b0;
        tick(5);
        check("t6b_idle", 32'(busy), 32'd0);

        // L=1024, period 2: 512 edges; 8-bit instance saturates
        gexp = 4'd6;
        sig_half = 1;
        tick(4);
        start = 1'b1;
        wait_busy(1'b1, 10, "t4_enter");
        start = 1'b0;
        wait_busy(1'b0, 1100, "t4_done");
        byte_sel = 1'b1;
        #1;
        check("t4_main_hi", 32'(pins.uo_out), 32'h02);
        check("t4_sat_hi", 32'(pins_s.uo_out), 32'h00);
        byte_sel = 1'b0;
        #1;
        check("t4_main_lo", 32'(pins.uo_out), 32'h00);
        check("t4_sat_lo", 32'(pins_s.uo_out), 32'hFF);
        check("t4_main_ovf", 32'(ovf), 32'd0);
        check("t4_sat_ovf", 32'(pins_s.uio_out[2]), 32'd1);
        check("t4_sat_valid", 32'(pins_s.uio_out[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
